// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the two-port data-memory arbiter.
package dmem_arb_pkg;

    // Default memory geometry: 16 words of 8 bits.
    localparam int unsigned AW_DEF = 4;
    localparam int unsigned DW_DEF = 8;

    // Sequencer states. Every transaction returns to IDLE, which doubles as
    // the bus turnaround cycle between a write and the next read.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WR     = 2'b01,
        RD     = 2'b10,
        RD_CAP = 2'b11
    } arb_state_t;

    // Requester identity.
    typedef enum logic {
        P0 = 1'b0,
        P1 = 1'b1
    } port_sel_t;

    // The port that is not p; used to alternate grants under contention.
    function automatic port_sel_t other_port(input port_sel_t p);
        port_sel_t r;
        case (p)
            P0:      r = P1;
            P1:      r = P0;
            default: r = P0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-requester picker. Under contention it either alternates
// against the last grant (round-robin) or always favours port 0.
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic      i_req0,
    input  logic      i_req1,
    input  port_sel_t i_last_gnt,
    input  logic      i_rr,
    output port_sel_t o_sel,
    output logic      o_any
);

    // Pick the winner among the currently asserted requests.
    always_comb begin
        o_sel = P0;
        o_any = i_req0 | i_req1;
        if (i_req0 && i_req1) begin
            if (i_rr) begin
                o_sel = other_port(i_last_gnt);
            end else begin
                o_sel = P0;
            end
        end else if (i_req1) begin
            o_sel = P1;
        end else begin
            o_sel = P0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer for the shared data memory. Port 0 is the
// CPU load/store path, port 1 the debug/DMA loader. One transaction is in
// flight at a time; the arbiter owns the data bus only while writing.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW       = AW_DEF,
    parameter int unsigned DW       = DW_DEF,
    parameter bit          RR       = 1'b1,
    parameter int unsigned READ_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,

    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,

    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic          mem_oe,
    inout  wire  [DW-1:0] mem_data,
    output logic          busy
);

    // Value of the read counter on the last RD cycle (RD lasts READ_LAT+1 cycles).
    localparam logic [1:0] RD_LAST = 2'(READ_LAT);

    arb_state_t    r_state;
    logic [1:0]    r_cnt;
    port_sel_t     r_sel;
    port_sel_t     r_last_gnt;
    logic [DW-1:0] r_wdata;
    logic [AW-1:0] r_mem_addr;
    logic          r_mem_we;
    logic          r_mem_oe;
    logic          r_busy;
    logic          r_gnt0;
    logic          r_gnt1;
    logic          r_rvalid0;
    logic          r_rvalid1;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;

    port_sel_t     w_sel;
    logic          w_any;
    logic          w_win_we;
    logic [AW-1:0] w_win_addr;
    logic [DW-1:0] w_win_wdata;

    rr_pick2 u_pick (
        .i_req0     (req0),
        .i_req1     (req1),
        .i_last_gnt (r_last_gnt),
        .i_rr       (RR),
        .o_sel      (w_sel),
        .o_any      (w_any)
    );

    // Route the selected requester's fields toward the latch registers.
    always_comb begin
        w_win_we    = we0;
        w_win_addr  = addr0;
        w_win_wdata = wdata0;
        if (w_sel == P1) begin
            w_win_we    = we1;
            w_win_addr  = addr1;
            w_win_wdata = wdata1;
        end else begin
            w_win_we    = we0;
            w_win_addr  = addr0;
            w_win_wdata = wdata0;
        end
    end

    // Sequencer: arbitration, request latching, memory strobes and read return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= 2'd0;
            r_sel      <= P0;
            r_last_gnt <= P1;
            r_wdata    <= {DW{1'b0}};
            r_mem_addr <= {AW{1'b0}};
            r_mem_we   <= 1'b0;
            r_mem_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
            r_rdata0   <= {DW{1'b0}};
            r_rdata1   <= {DW{1'b0}};
        end else begin
            // Grant and read-valid are single-cycle pulses.
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_sel      <= w_sel;
                        r_last_gnt <= w_sel;
                        r_mem_addr <= w_win_addr;
                        r_wdata    <= w_win_wdata;
                        r_cnt      <= 2'd0;
                        r_busy     <= 1'b1;
                        r_gnt0     <= (w_sel == P0);
                        r_gnt1     <= (w_sel == P1);
                        if (w_win_we) begin
                            r_state  <= WR;
                            r_mem_we <= 1'b1;
                            r_mem_oe <= 1'b0;
                        end else begin
                            r_state  <= RD;
                            r_mem_we <= 1'b0;
                            r_mem_oe <= 1'b1;
                        end
                    end else begin
                        r_state  <= IDLE;
                        r_busy   <= 1'b0;
                        r_mem_we <= 1'b0;
                        r_mem_oe <= 1'b0;
                    end
                end
                WR: begin
                    // The memory commits the write on the edge that ends WR.
                    r_state  <= IDLE;
                    r_mem_we <= 1'b0;
                    r_mem_oe <= 1'b0;
                    r_busy   <= 1'b0;
                end
                RD: begin
                    if (r_cnt == RD_LAST) begin
                        r_state <= RD_CAP;
                    end else begin
                        r_state <= RD;
                        r_cnt   <= r_cnt + 2'd1;
                    end
                end
                RD_CAP: begin
                    // Bus is sampled here while mem_oe is still asserted.
                    r_state  <= IDLE;
                    r_mem_oe <= 1'b0;
                    r_busy   <= 1'b0;
                    if (r_sel == P1) begin
                        r_rdata1  <= mem_data;
                        r_rvalid1 <= 1'b1;
                    end else begin
                        r_rdata0  <= mem_data;
                        r_rvalid0 <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_mem_we <= 1'b0;
                    r_mem_oe <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    // The bus is driven only while in WR, so it floats in every other state,
    // including the instant reset asserts.
    assign mem_data = (r_state == WR) ? r_wdata : {DW{1'bz}};

    assign mem_addr = r_mem_addr;
    assign mem_we   = r_mem_we;
    assign mem_oe   = r_mem_oe;
    assign busy     = r_busy;
    assign gnt0     = r_gnt0;
    assign gnt1     = r_gnt1;
    assign rvalid0  = r_rvalid0;
    assign rvalid1  = r_rvalid1;
    assign rdata0   = r_rdata0;
    assign rdata1   = r_rdata1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter. Two instances run side by side:
// index 0 is round-robin with READ_LAT=1, index 1 is fixed priority with
// READ_LAT=3. A transaction-level model predicts each cycle's outputs from
// the grant cycle and the documented transaction lengths.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       s_req    [2][2];
    logic       s_we     [2][2];
    logic [3:0] s_addr   [2][2];
    logic [7:0] s_wdata  [2][2];
    logic       o_gnt    [2][2];
    logic       o_rvalid [2][2];
    logic [7:0] o_rdata  [2][2];
    logic [3:0] o_maddr  [2];
    logic       o_mwe    [2];
    logic       o_moe    [2];
    logic       o_busy   [2];
    wire  [7:0] bus_a;
    wire  [7:0] bus_b;
    logic [7:0] dev_a [16];
    logic [7:0] dev_b [16];

    dmem_arbiter #(.AW(4), .DW(8), .RR(1'b1), .READ_LAT(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .req0(s_req[0][0]), .we0(s_we[0][0]), .addr0(s_addr[0][0]), .wdata0(s_wdata[0][0]),
        .gnt0(o_gnt[0][0]), .rvalid0(o_rvalid[0][0]), .rdata0(o_rdata[0][0]),
        .req1(s_req[0][1]), .we1(s_we[0][1]), .addr1(s_addr[0][1]), .wdata1(s_wdata[0][1]),
        .gnt1(o_gnt[0][1]), .rvalid1(o_rvalid[0][1]), .rdata1(o_rdata[0][1]),
        .mem_addr(o_maddr[0]), .mem_we(o_mwe[0]), .mem_oe(o_moe[0]),
        .mem_data(bus_a), .busy(o_busy[0])
    );

    dmem_arbiter #(.AW(4), .DW(8), .RR(1'b0), .READ_LAT(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0(s_req[1][0]), .we0(s_we[1][0]), .addr0(s_addr[1][0]), .wdata0(s_wdata[1][0]),
        .gnt0(o_gnt[1][0]), .rvalid0(o_rvalid[1][0]), .rdata0(o_rdata[1][0]),
        .req1(s_req[1][1]), .we1(s_we[1][1]), .addr1(s_addr[1][1]), .wdata1(s_wdata[1][1]),
        .gnt1(o_gnt[1][1]), .rvalid1(o_rvalid[1][1]), .rdata1(o_rdata[1][1]),
        .mem_addr(o_maddr[1]), .mem_we(o_mwe[1]), .mem_oe(o_moe[1]),
        .mem_data(bus_b), .busy(o_busy[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic bit rr_of(input int d);
        return (d == 0);
    endfunction

    function automatic logic [7:0] fill_val(input int d, input int a);
        return 8'((a * 37 + 11 + d * 101) & 255);
    endfunction

    // Memory devices: drive the bus only when output-enabled and not writing.
    assign bus_a = (o_moe[0] && !o_mwe[0]) ? dev_a[o_maddr[0]] : 8'bzzzz_zzzz;
    assign bus_b = (o_moe[1] && !o_mwe[1]) ? dev_b[o_maddr[1]] : 8'bzzzz_zzzz;

    // Device memory A: known contents at reset, written from the bus on mem_we.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < 16; a++) dev_a[a] <= fill_val(0, a);
        end else if (o_mwe[0]) begin
            dev_a[o_maddr[0]] <= bus_a;
        end
    end

    // Device memory B: same behaviour for the second instance.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < 16; a++) dev_b[a] <= fill_val(1, a);
        end else if (o_mwe[1]) begin
            dev_b[o_maddr[1]] <= bus_b;
        end
    end

    // Reference model state
    int unsigned cyc;
    int          rate;
    int          n_tests;
    int          n_fail;
    int          last_gnt  [2];
    bit          t_valid   [2];
    int unsigned t_k       [2];
    int          t_port    [2];
    bit          t_we      [2];
    logic [3:0]  t_addr    [2];
    logic [7:0]  t_wdata   [2];
    logic [7:0]  t_rexp    [2];
    int unsigned next_free [2];
    logic [7:0]  m_rdata   [2][2];
    logic [7:0]  ref_mem   [2][16];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            last_gnt[d]  = 1;
            t_valid[d]   = 1'b0;
            next_free[d] = cyc;
            for (int p = 0; p < 2; p++) begin
                m_rdata[d][p] = 8'h00;
                s_req[d][p]   = 1'b0;
            end
            for (int a = 0; a < 16; a++) ref_mem[d][a] = fill_val(d, a);
        end
    endtask

    task automatic set_req(input int d, input int p, input bit we, input logic [3:0] addr,
                           input logic [7:0] wdata);
        s_req[d][p]   = 1'b1;
        s_we[d][p]    = we;
        s_addr[d][p]  = addr;
        s_wdata[d][p] = wdata;
    endtask

    task automatic check_reset(input int d);
        string pfx;
        pfx = $sformatf("rst d%0d", d);
        check_val({pfx, " gnt0"},    32'(o_gnt[d][0]),    32'd0);
        check_val({pfx, " gnt1"},    32'(o_gnt[d][1]),    32'd0);
        check_val({pfx, " rvalid0"}, 32'(o_rvalid[d][0]), 32'd0);
        check_val({pfx, " rvalid1"}, 32'(o_rvalid[d][1]), 32'd0);
        check_val({pfx, " rdata0"},  32'(o_rdata[d][0]),  32'd0);
        check_val({pfx, " rdata1"},  32'(o_rdata[d][1]),  32'd0);
        check_val({pfx, " busy"},    32'(o_busy[d]),      32'd0);
        check_val({pfx, " mem_we"},  32'(o_mwe[d]),       32'd0);
        check_val({pfx, " mem_oe"},  32'(o_moe[d]),       32'd0);
        check_val({pfx, " mem_addr"}, 32'(o_maddr[d]),    32'd0);
    endtask

    task automatic check_cycle(input int d);
        int unsigned last_busy;
        bit          busy_e, we_e, oe_e;
        bit          g [2];
        bit          rv [2];
        logic [7:0]  bus;
        string       pfx;
        busy_e = 1'b0; we_e = 1'b0; oe_e = 1'b0;
        g[0] = 1'b0; g[1] = 1'b0; rv[0] = 1'b0; rv[1] = 1'b0;
        bus = (d == 0) ? bus_a : bus_b;
        pfx = $sformatf("c%0d d%0d", cyc, d);
        if (t_valid[d]) begin
            last_busy = t_we[d] ? t_k[d] : t_k[d] + 32'(lat_of(d)) + 32'd1;
            busy_e = (cyc >= t_k[d]) && (cyc <= last_busy);
            we_e   = t_we[d] && (cyc == t_k[d]);
            oe_e   = !t_we[d] && busy_e;
            g[t_port[d]] = (cyc == t_k[d]);
            if (!t_we[d] && cyc == t_k[d] + 32'(lat_of(d)) + 32'd2) begin
                rv[t_port[d]] = 1'b1;
                m_rdata[d][t_port[d]] = t_rexp[d];
            end
        end
        check_val({pfx, " gnt0"},    32'(o_gnt[d][0]),    32'(g[0]));
        check_val({pfx, " gnt1"},    32'(o_gnt[d][1]),    32'(g[1]));
        check_val({pfx, " gnt_both"}, 32'(o_gnt[d][0] & o_gnt[d][1]), 32'd0);
        check_val({pfx, " rvalid0"}, 32'(o_rvalid[d][0]), 32'(rv[0]));
        check_val({pfx, " rvalid1"}, 32'(o_rvalid[d][1]), 32'(rv[1]));
        check_val({pfx, " rdata0"},  32'(o_rdata[d][0]),  32'(m_rdata[d][0]));
        check_val({pfx, " rdata1"},  32'(o_rdata[d][1]),  32'(m_rdata[d][1]));
        check_val({pfx, " busy"},    32'(o_busy[d]),      32'(busy_e));
        check_val({pfx, " mem_we"},  32'(o_mwe[d]),       32'(we_e));
        check_val({pfx, " mem_oe"},  32'(o_moe[d]),       32'(oe_e));
        check_val({pfx, " we_and_oe"}, 32'(o_mwe[d] & o_moe[d]), 32'd0);
        if (busy_e) check_val({pfx, " mem_addr"}, 32'(o_maddr[d]), 32'(t_addr[d]));
        if (we_e)   check_val({pfx, " bus_wdata"}, 32'(bus), 32'(t_wdata[d]));
    endtask

    // Requesters: drop a request once its grant is seen, then maybe raise a new one.
    task automatic drive(input int d);
        logic [3:0] a;
        for (int p = 0; p < 2; p++) begin
            if (s_req[d][p] && t_valid[d] && t_k[d] == cyc && t_port[d] == p) s_req[d][p] = 1'b0;
            if (!s_req[d][p] && $urandom_range(0, 99) < rate) begin
                a = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
                set_req(d, p, 1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255)));
            end
        end
    endtask

    // Arbitration rule applied whenever the arbiter is idle in this cycle.
    task automatic schedule(input int d);
        int w;
        if (cyc >= next_free[d] && (s_req[d][0] || s_req[d][1])) begin
            if (s_req[d][0] && s_req[d][1]) w = rr_of(d) ? 1 - last_gnt[d] : 0;
            else w = s_req[d][1] ? 1 : 0;
            last_gnt[d] = w;
            t_valid[d]  = 1'b1;
            t_k[d]      = cyc + 32'd1;
            t_port[d]   = w;
            t_we[d]     = s_we[d][w];
            t_addr[d]   = s_addr[d][w];
            t_wdata[d]  = s_wdata[d][w];
            if (t_we[d]) begin
                ref_mem[d][t_addr[d]] = t_wdata[d];
                next_free[d] = cyc + 32'd2;
            end else begin
                t_rexp[d] = ref_mem[d][t_addr[d]];
                next_free[d] = cyc + 32'(lat_of(d)) + 32'd3;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        for (int d = 0; d < 2; d++) check_cycle(d);
        for (int d = 0; d < 2; d++) drive(d);
        for (int d = 0; d < 2; d++) schedule(d);
    endtask

    function automatic bit all_idle();
        bit r;
        r = 1'b1;
        for (int d = 0; d < 2; d++)
            if (s_req[d][0] || s_req[d][1] || cyc < next_free[d]) r = 1'b0;
        return r;
    endfunction

    task automatic quiesce();
        rate = 0;
        for (int i = 0; i < 200 && !all_idle(); i++) step();
        check_val("quiesce", 32'(all_idle()), 32'd1);
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; rate = 0;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) begin
                s_req[d][p] = 1'b0; s_we[d][p] = 1'b0;
                s_addr[d][p] = 4'h0; s_wdata[d][p] = 8'h00;
            end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) check_reset(d);
        rst_n = 1'b1;
        model_reset();

        // Directed: port 0 writes 0xA5 to address 3, then port 1 reads it back.
        for (int d = 0; d < 2; d++) begin
            set_req(d, 0, 1'b1, 4'd3, 8'hA5);
            schedule(d);
        end
        repeat (3) step();
        for (int d = 0; d < 2; d++) begin
            set_req(d, 1, 1'b0, 4'd3, 8'h00);
            schedule(d);
        end
        repeat (10) step();
        check_val("dir rdata1 d0", 32'(o_rdata[0][1]), 32'h0000_00A5);

        // Dense contention, then sparse traffic.
        rate = 90;
        repeat (400) step();
        rate = 20;
        repeat (400) step();
        quiesce();

        // Reset while a port-1 read is in RD.
        for (int d = 0; d < 2; d++) begin
            set_req(d, 1, 1'b0, 4'd2, 8'h00);
            schedule(d);
        end
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) check_reset(d);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // First contention after reset must go to port 0 on both instances.
        for (int d = 0; d < 2; d++) begin
            set_req(d, 0, 1'b1, 4'd1, 8'($urandom_range(0, 255)));
            set_req(d, 1, 1'b1, 4'd0, 8'($urandom_range(0, 255)));
            schedule(d);
        end
        step();
        check_val("post-rst gnt0 d0", 32'(o_gnt[0][0]), 32'd1);
        check_val("post-rst gnt0 d1", 32'(o_gnt[1][0]), 32'd1);
        rate = 50;
        repeat (300) step();
        quiesce();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer for the shared 8-bit data memory: 16 words, bidirectional data bus, we/oe control.
- Port 0 is the CPU load/store path. Port 1 is the debug/DMA loader.
- Grants one requester at a time, drives the memory control and address lines, and owns the tri-state bus during writes.
- Captures read data and returns it to the winning port with a valid pulse.

Parameters:
- AW, 4, memory address width.
- DW, 8, data width.
- RR, 1, 1 = round-robin between ports; 0 = fixed priority, port 0 always wins.
- READ_LAT, 1, extra cycles mem_oe is held before the arbiter samples mem_data (range 0–3).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0  in  1  port 0 request; held until gnt0.
- we0  in  1  port 0 write (1) / read (0).
- addr0  in  AW  port 0 address.
- wdata0  in  DW  port 0 write data.
- gnt0  out  1  one-cycle grant pulse; request fields have been latched.
- rvalid0  out  1  one-cycle read-data-valid pulse.
- rdata0  out  DW  port 0 read data; held until the next port 0 read completes.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: identical to the port 0 set, for port 1.
- mem_addr  out  AW  memory address.
- mem_we  out  1  memory write enable.
- mem_oe  out  1  memory output enable.
- mem_data  inout  DW  shared memory data bus.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; mem_we=0, mem_oe=0, mem_addr=0.
  - mem_data released (high-Z) immediately.
  - gnt*, rvalid*, rdata* = 0; busy=0; last_gnt=1, so port 0 wins the first contention.
- Any in-flight read is abandoned: no rvalid is issued and rdata is not updated.
- FSM states: IDLE, WR, RD, RD_CAP.
- IDLE, at each rising edge:
  - If any req is high, select a winner:
    - RR=1: when both request, pick the port opposite last_gnt.
    - RR=0: port 0 always wins.
  - Latch the winner's we, addr and wdata into internal registers; update last_gnt.
  - Next state is WR if we=1, else RD.
  - gnt of the winner is high for exactly the first cycle of WR or RD.
  - The requester may change or drop its fields after the edge where gnt is seen.
- WR (1 cycle):
  - mem_we=1, mem_oe=0, mem_addr=latched addr, mem_data driven with latched wdata.
  - Memory writes on the rising edge that ends this cycle.
  - Next state: IDLE.
- RD (READ_LAT+1 cycles, counted by a 2-bit counter):
  - mem_we=0, mem_oe=1, mem_addr=latched addr, mem_data high-Z.
  - Next state: RD_CAP after the final cycle.
- RD_CAP (1 cycle):
  - mem_oe still 1; mem_data is sampled at the rising edge that ends this cycle.
  - At that edge, rdata of the granted port is loaded and its rvalid pulses high for the following cycle.
  - Next state: IDLE.
- Bus ownership:
  - The arbiter drives mem_data only when state==WR.
  - mem_we and mem_oe are never both 1.
  - Every transaction ends in IDLE, which provides a turnaround cycle.
- Throughput:
  - Write: 2 cycles per transaction, including IDLE.
  - Read: READ_LAT+3 cycles per transaction.
  - Latency from req to rvalid is READ_LAT+3 cycles.
- Boundary conditions:
  - A req asserted while busy is ignored until the next IDLE; the loser's req stays pending.
  - The same port may win back-to-back only if the other port is not requesting.
  - Addresses 0 through 2^AW−1 pass through unmodified; there is no wrap logic.
  - rvalid and gnt for the same port never assert in the same cycle.
- All outputs are registered. The mem_data tri-state enable is decoded from the state register.

Decomposition:
- Package dmem_arb_pkg holds:
  - the state enum (IDLE, WR, RD, RD_CAP);
  - DW/AW defaults;
  - a port-select constant type (P0=0, P1=1).
- Sub-module rr_pick2: combinational two-requester picker (inputs: req0, req1, last_gnt, RR; outputs: sel, any).
- The FSM, the latches and the tri-state driver stay in dmem_arbiter.

Test Plan:
- Write through port 0:
  - Stimulus: port 0 writes addr=3, wdata=0xA5.
  - Response: gnt0 high one cycle; mem_we=1 with mem_addr=3 and mem_data=0xA5 in that same cycle; busy returns to 0 the next cycle.
- Read through port 1 (READ_LAT=1):
  - Stimulus: port 1 reads addr=3 after the write above.
  - Response: mem_oe high 3 cycles; rvalid1 pulses 4 cycles after req1 is sampled; rdata1=0xA5; rdata0 unchanged.
- Contention, RR=1:
  - Stimulus: req0 and req1 held high continuously, with writes to addr 0 and 1.
  - Response: grant order P0, P1, P0, P1; no cycle with both gnt high.
- Fixed priority, RR=0:
  - Stimulus: same contention as above.
  - Response: only gnt0 fires while req0 stays high; gnt1 fires the first IDLE after req0 drops.
- Reset mid-read:
  - Stimulus: rst_n pulled low during RD.
  - Response: mem_oe=0 and mem_data high-Z immediately; no rvalid; the first post-reset contention grants port 0.
- Bus hygiene, across all above scenarios:
  - mem_data is high-Z whenever state≠WR.
  - mem_we and mem_oe are never both 1.
